// File: rtl/parking_gate_arbiter_if.sv
// Lane-side and motor-side signals of the parking gate arbiter.
// The arbiter uses the slave modport; the master modport is for the lane/motor environment.
interface parking_gate_arbiter_if #(
  parameter int CNT_W = 4
);
  logic             entrance_req;
  logic [5:0]       entrance_pass;
  logic             exit_req;
  logic             door_max_open;
  logic             door_max_close;
  logic             door_open;
  logic             door_close;
  logic             ok_pass;
  logic             wrong_pass;
  logic [1:0]       lane_grant;
  logic [CNT_W-1:0] car_number;
  logic             empty;
  logic             full;
  logic             busy;
  logic             fault;

  modport master (
    output entrance_req, entrance_pass, exit_req, door_max_open, door_max_close,
    input  door_open, door_close, ok_pass, wrong_pass, lane_grant,
           car_number, empty, full, busy, fault
  );

  modport slave (
    input  entrance_req, entrance_pass, exit_req, door_max_open, door_max_close,
    output door_open, door_close, ok_pass, wrong_pass, lane_grant,
           car_number, empty, full, busy, fault
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Shares one parking-lot door between entrance and exit lanes: round-robin arbitration,
// password check, open/hold/close motor sequencing, occupancy count and sticky fault.
module parking_gate_arbiter #(
  parameter int CAPACITY      = 10,
  parameter int INIT_COUNT    = 0,
  parameter int HOLD_CYCLES   = 16,
  parameter int MOTOR_TIMEOUT = 255,
  parameter int CNT_W         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  parking_gate_arbiter_if.slave  gate
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_OPEN, S_HOLD, S_CLOSE, S_COMMIT, S_FAULT
  } state_t;

  localparam int TMR_MAX = (MOTOR_TIMEOUT > HOLD_CYCLES) ? MOTOR_TIMEOUT : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] INIT_C    = CNT_W'(INIT_COUNT);
  localparam logic [TMR_W-1:0] TOUT_LAST = TMR_W'(MOTOR_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic             INIT_EMPTY = (INIT_COUNT == 0);
  localparam logic             INIT_FULL  = (INIT_COUNT == CAPACITY);

  function automatic logic pass_valid(input logic [5:0] p);
    return (p == 6'd3)  | (p == 6'd7)  | (p == 6'd35) | (p == 6'd38) | (p == 6'd39) |
           (p == 6'd44) | (p == 6'd47) | (p == 6'd51) | (p == 6'd55) | (p == 6'd63);
  endfunction

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_exit_q, last_exit_d;
  logic             lock_q, lock_d;
  logic             open_q, open_d;
  logic             close_q, close_d;
  logic             ok_q, ok_d;
  logic             wrong_q, wrong_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;

  logic ent_elig, ex_elig, both_lim;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    count_d     = count_q;
    grant_d     = grant_q;
    last_exit_d = last_exit_q;
    lock_d      = lock_q;
    ok_d        = 1'b0;
    wrong_d     = 1'b0;

    ent_elig = gate.entrance_req && !lock_q;
    ex_elig  = gate.exit_req && !empty_q;
    both_lim = gate.door_max_open && gate.door_max_close;

    // The lockout only releases once the car has actually left the entrance sensor.
    if (!gate.entrance_req) lock_d = 1'b0;

    if (state_q != S_IDLE && both_lim) begin
      state_d = S_FAULT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ent_elig && (!ex_elig || last_exit_q)) begin
            state_d = S_CHECK;
            grant_d = 2'b01;
          end else if (ex_elig) begin
            state_d = S_OPEN;
            grant_d = 2'b10;
            timer_d = '0;
          end
        end
        S_CHECK: begin
          if (pass_valid(gate.entrance_pass) && !full_q) begin
            ok_d    = 1'b1;
            state_d = S_OPEN;
            timer_d = '0;
          end else begin
            wrong_d = 1'b1;
            lock_d  = 1'b1;
            grant_d = 2'b00;
            state_d = S_IDLE;
          end
        end
        S_OPEN: begin
          if (gate.door_max_open) begin
            state_d = S_HOLD;
            timer_d = '0;
          end else if (timer_q == TOUT_LAST) begin
            state_d = S_FAULT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (timer_q == HOLD_LAST) begin
            state_d = S_CLOSE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_CLOSE: begin
          if (gate.door_max_close) begin
            state_d = S_COMMIT;
          end else if (timer_q == TOUT_LAST) begin
            state_d = S_FAULT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_COMMIT: begin
          if (grant_q[0]) begin
            if (count_q != CAP_C) count_d = count_q + 1'b1;
          end else begin
            if (count_q != '0) count_d = count_q - 1'b1;
          end
          last_exit_d = grant_q[1];
          grant_d     = 2'b00;
          state_d     = S_IDLE;
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_FAULT;
      endcase
    end

    // Outputs are registered from the next state so they line up with the state change.
    open_d  = (state_d == S_OPEN);
    close_d = (state_d == S_CLOSE);
    busy_d  = (state_d != S_IDLE);
    fault_d = (state_d == S_FAULT);
    if (fault_d) grant_d = 2'b00;
    empty_d = (count_d == '0);
    full_d  = (count_d == CAP_C);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      count_q     <= INIT_C;
      empty_q     <= INIT_EMPTY;
      full_q      <= INIT_FULL;
      grant_q     <= 2'b00;
      last_exit_q <= 1'b1;
      lock_q      <= 1'b0;
      open_q      <= 1'b0;
      close_q     <= 1'b0;
      ok_q        <= 1'b0;
      wrong_q     <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      grant_q     <= grant_d;
      last_exit_q <= last_exit_d;
      lock_q      <= lock_d;
      open_q      <= open_d;
      close_q     <= close_d;
      ok_q        <= ok_d;
      wrong_q     <= wrong_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
    end
  end

  assign gate.door_open  = open_q;
  assign gate.door_close = close_q;
  assign gate.ok_pass    = ok_q;
  assign gate.wrong_pass = wrong_q;
  assign gate.lane_grant = grant_q;
  assign gate.car_number = count_q;
  assign gate.empty      = empty_q;
  assign gate.full       = full_q;
  assign gate.busy       = busy_q;
  assign gate.fault      = fault_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: password table, directed lane/door sequences and
// randomized traffic against a procedural cycle-level reference model.
`timescale 1ns/1ps
module tb_parking_gate_arbiter;
  localparam int CAP  = 10;
  localparam int INIT = 0;
  localparam int HOLD = 16;
  localparam int TOUT = 255;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       ereq = 1'b0, xreq = 1'b0, mo = 1'b0, mc = 1'b0;
  logic [5:0] epass = 6'd0;

  parking_gate_arbiter_if #(.CNT_W(CW)) gif ();
  assign gif.entrance_req   = ereq;
  assign gif.entrance_pass  = epass;
  assign gif.exit_req       = xreq;
  assign gif.door_max_open  = mo;
  assign gif.door_max_close = mc;

  parking_gate_arbiter #(
    .CAPACITY(CAP), .INIT_COUNT(INIT), .HOLD_CYCLES(HOLD),
    .MOTOR_TIMEOUT(TOUT), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .gate (gif)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  logic [5:0] vpw [10];
  initial vpw = '{6'd3, 6'd7, 6'd35, 6'd38, 6'd39, 6'd44, 6'd47, 6'd51, 6'd55, 6'd63};

  function automatic bit pw_ok(input logic [5:0] p);
    for (int i = 0; i < 10; i++) if (vpw[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: the protocol told as a story of edges, one tick per rising clock.
  bit s_ereq, s_xreq, s_mo, s_mc, s_rst;
  logic [5:0] s_pass;
  bit m_lock = 0, lock_prev = 0, m_last_exit = 1, m_rst = 0;
  bit e_open = 0, e_close = 0, e_ok = 0, e_wrong = 0, e_busy = 0, e_fault = 0;
  logic [1:0] e_grant = 2'b00;
  int e_cars = INIT;

  task automatic tick();
    @(posedge clk);
    s_ereq = ereq; s_xreq = xreq; s_mo = mo; s_mc = mc; s_pass = epass; s_rst = rst_n;
    e_ok = 0; e_wrong = 0;
    lock_prev = m_lock;
    if (!s_rst) begin
      m_rst = 1; m_lock = 0; m_last_exit = 1; e_cars = INIT;
      e_open = 0; e_close = 0; e_busy = 0; e_fault = 0; e_grant = 2'b00;
      return;
    end
    if (!s_ereq) m_lock = 0;
  endtask

  task automatic fault_forever();
    e_open = 0; e_close = 0; e_grant = 2'b00; e_busy = 1; e_fault = 1;
    while (1) begin
      tick();
      if (m_rst) return;
    end
  endtask

  task automatic ref_sequence();
    bit ent, picked, go_ent, go_ex, moved;
    int n;
    picked = 0; ent = 0;
    while (!picked) begin
      tick();
      if (m_rst) return;
      go_ent = s_ereq && !lock_prev;
      go_ex  = s_xreq && (e_cars != 0);
      if (go_ent && go_ex) begin ent = m_last_exit; picked = 1; end
      else if (go_ent) begin ent = 1; picked = 1; end
      else if (go_ex) begin ent = 0; picked = 1; end
    end
    e_busy = 1;
    e_grant = ent ? 2'b01 : 2'b10;
    if (ent) begin
      tick();
      if (m_rst) return;
      if (s_mo && s_mc) begin fault_forever(); return; end
      if (pw_ok(s_pass) && e_cars != CAP) e_ok = 1;
      else begin
        e_wrong = 1; m_lock = 1; e_grant = 2'b00; e_busy = 0;
        return;
      end
    end
    e_open = 1; n = 0; moved = 0;
    while (!moved) begin
      tick();
      if (m_rst) return;
      if (s_mo && s_mc) begin fault_forever(); return; end
      if (s_mo) moved = 1;
      else begin n++; if (n == TOUT) begin fault_forever(); return; end end
    end
    e_open = 0;
    for (int h = 0; h < HOLD; h++) begin
      tick();
      if (m_rst) return;
      if (s_mo && s_mc) begin fault_forever(); return; end
    end
    e_close = 1; n = 0; moved = 0;
    while (!moved) begin
      tick();
      if (m_rst) return;
      if (s_mo && s_mc) begin fault_forever(); return; end
      if (s_mc) moved = 1;
      else begin n++; if (n == TOUT) begin fault_forever(); return; end end
    end
    e_close = 0;
    tick();
    if (m_rst) return;
    if (s_mo && s_mc) begin fault_forever(); return; end
    if (ent) e_cars = (e_cars == CAP) ? CAP : e_cars + 1;
    else     e_cars = (e_cars == 0) ? 0 : e_cars - 1;
    m_last_exit = !ent; e_grant = 2'b00; e_busy = 0;
  endtask

  initial begin : ref_model
    forever begin
      m_rst = 0;
      ref_sequence();
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_outputs",
        32'({gif.door_open, gif.door_close, gif.ok_pass, gif.wrong_pass, gif.lane_grant,
             gif.car_number, gif.empty, gif.full, gif.busy, gif.fault}),
        32'({e_open, e_close, e_ok, e_wrong, e_grant, CW'(e_cars),
             (e_cars == 0), (e_cars == CAP), e_busy, e_fault}));
      check("grant_onehot", 32'($countones(gif.lane_grant) <= 1), 32'd1);
      check("drives_exclusive", 32'(gif.door_open & gif.door_close), 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ereq = 0; xreq = 0; mo = 0; mc = 0; epass = 6'd0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic door_cycle();
    mo = 1; step(1); mo = 0;
    check("hold_open_off", 32'(gif.door_open), 32'd0);
    step(HOLD - 1);
    check("hold_no_close", 32'(gif.door_close), 32'd0);
    step(1);
    check("close_on", 32'(gif.door_close), 32'd1);
    mc = 1; step(1); mc = 0;
    check("commit_close_off", 32'(gif.door_close), 32'd0);
    step(1);
    check("idle_after_commit", 32'(gif.busy), 32'd0);
  endtask

  task automatic enter_car(input logic [5:0] p);
    ereq = 1; epass = p; step(2);
    check("enter_ok", 32'(gif.ok_pass), 32'd1);
    check("enter_open", 32'(gif.door_open), 32'd1);
    ereq = 0;
    door_cycle();
  endtask

  task automatic exit_car();
    xreq = 1; step(1);
    check("exit_grant", 32'(gif.lane_grant), 32'd2);
    check("exit_open", 32'(gif.door_open), 32'd1);
    xreq = 0;
    door_cycle();
  endtask

  typedef struct packed {
    logic [5:0] pass;
    logic       ok;
    logic       wrong;
    logic       open;
    logic [1:0] grant;
  } pw_vec_t;
  pw_vec_t tbl[$];

  initial begin : main
    tbl.push_back({6'd3,  1'b1, 1'b0, 1'b1, 2'b01});
    tbl.push_back({6'd7,  1'b1, 1'b0, 1'b1, 2'b01});
    tbl.push_back({6'd35, 1'b1, 1'b0, 1'b1, 2'b01});
    tbl.push_back({6'd38, 1'b1, 1'b0, 1'b1, 2'b01});
    tbl.push_back({6'd39, 1'b1, 1'b0, 1'b1, 2'b01});
    tbl.push_back({6'd44, 1'b1, 1'b0, 1'b1, 2'b01});
    tbl.push_back({6'd47, 1'b1, 1'b0, 1'b1, 2'b01});
    tbl.push_back({6'd51, 1'b1, 1'b0, 1'b1, 2'b01});
    tbl.push_back({6'd55, 1'b1, 1'b0, 1'b1, 2'b01});
    tbl.push_back({6'd63, 1'b1, 1'b0, 1'b1, 2'b01});
    tbl.push_back({6'd0,  1'b0, 1'b1, 1'b0, 2'b00});
    tbl.push_back({6'd4,  1'b0, 1'b1, 1'b0, 2'b00});
    tbl.push_back({6'd36, 1'b0, 1'b1, 1'b0, 2'b00});
    tbl.push_back({6'd62, 1'b0, 1'b1, 1'b0, 2'b00});
    tbl.push_back({6'd1,  1'b0, 1'b1, 1'b0, 2'b00});
    tbl.push_back({6'd48, 1'b0, 1'b1, 1'b0, 2'b00});

    do_reset();
    chk_en = 1;
    check("rst_open",  32'(gif.door_open), 32'd0);
    check("rst_close", 32'(gif.door_close), 32'd0);
    check("rst_grant", 32'(gif.lane_grant), 32'd0);
    check("rst_cars",  32'(gif.car_number), 32'(INIT));
    check("rst_empty", 32'(gif.empty), 32'd1);
    check("rst_full",  32'(gif.full), 32'd0);
    check("rst_busy",  32'(gif.busy), 32'd0);
    check("rst_fault", 32'(gif.fault), 32'd0);

    foreach (tbl[i]) begin
      do_reset();
      ereq = 1; epass = tbl[i].pass; step(2);
      check($sformatf("pw%0d_ok", tbl[i].pass), 32'(gif.ok_pass), 32'(tbl[i].ok));
      check($sformatf("pw%0d_wrong", tbl[i].pass), 32'(gif.wrong_pass), 32'(tbl[i].wrong));
      check($sformatf("pw%0d_open", tbl[i].pass), 32'(gif.door_open), 32'(tbl[i].open));
      check($sformatf("pw%0d_grant", tbl[i].pass), 32'(gif.lane_grant), 32'(tbl[i].grant));
      ereq = 0;
    end

    // Entrance latency and first commit
    do_reset();
    ereq = 1; epass = 6'd35; step(1);
    check("t1_check_grant", 32'(gif.lane_grant), 32'd1);
    check("t1_no_open_yet", 32'(gif.door_open), 32'd0);
    step(1);
    check("t1_ok", 32'(gif.ok_pass), 32'd1);
    check("t1_open", 32'(gif.door_open), 32'd1);
    ereq = 0;
    door_cycle();
    check("t1_cars", 32'(gif.car_number), 32'd1);
    check("t1_empty", 32'(gif.empty), 32'd0);

    // Wrong password and lockout
    do_reset();
    ereq = 1; epass = 6'd4; step(2);
    check("t2_wrong", 32'(gif.wrong_pass), 32'd1);
    check("t2_no_open", 32'(gif.door_open), 32'd0);
    epass = 6'd3; step(4);
    check("t2_locked", 32'(gif.busy), 32'd0);
    ereq = 0; step(1);
    ereq = 1; step(2);
    check("t2_ok_after_release", 32'(gif.ok_pass), 32'd1);
    ereq = 0;
    door_cycle();

    // Full lot
    do_reset();
    repeat (CAP) enter_car(6'd7);
    check("t3_cars_full", 32'(gif.car_number), 32'(CAP));
    check("t3_full", 32'(gif.full), 32'd1);
    ereq = 1; epass = 6'd3; step(2);
    check("t3_wrong_full", 32'(gif.wrong_pass), 32'd1);
    check("t3_no_open", 32'(gif.door_open), 32'd0);
    ereq = 0; step(1);
    exit_car();
    check("t3_cars_after_exit", 32'(gif.car_number), 32'(CAP - 1));
    check("t3_not_full", 32'(gif.full), 32'd0);

    // Simultaneous requests after an exit was served last
    do_reset();
    repeat (6) enter_car(6'd35);
    exit_car();
    ereq = 1; epass = 6'd38; xreq = 1; step(1);
    check("t4_entrance_first", 32'(gif.lane_grant), 32'd1);
    step(1);
    check("t4_ok", 32'(gif.ok_pass), 32'd1);
    ereq = 0;
    door_cycle();
    check("t4_cars6", 32'(gif.car_number), 32'd6);
    step(1);
    check("t4_exit_next", 32'(gif.lane_grant), 32'd2);
    check("t4_exit_open", 32'(gif.door_open), 32'd1);
    xreq = 0;
    door_cycle();
    check("t4_cars5", 32'(gif.car_number), 32'd5);

    // Exit while empty, then motor timeout
    do_reset();
    xreq = 1; step(3);
    check("t5_empty_no_busy", 32'(gif.busy), 32'd0);
    check("t5_empty_no_grant", 32'(gif.lane_grant), 32'd0);
    xreq = 0;
    ereq = 1; epass = 6'd63; step(2);
    check("t5_open", 32'(gif.door_open), 32'd1);
    ereq = 0;
    step(TOUT - 1);
    check("t5_no_fault_yet", 32'(gif.fault), 32'd0);
    step(1);
    check("t5_fault", 32'(gif.fault), 32'd1);
    check("t5_drive_off", 32'(gif.door_open), 32'd0);
    check("t5_busy", 32'(gif.busy), 32'd1);
    ereq = 1; epass = 6'd3; step(3);
    check("t5_fault_sticky", 32'(gif.fault), 32'd1);
    do_reset();
    check("t5_fault_cleared", 32'(gif.fault), 32'd0);
    check("t5_cars_init", 32'(gif.car_number), 32'(INIT));

    // Reset during CLOSE
    do_reset();
    enter_car(6'd44);
    ereq = 1; epass = 6'd47; step(2);
    ereq = 0;
    mo = 1; step(1); mo = 0;
    step(HOLD);
    check("t6_closing", 32'(gif.door_close), 32'd1);
    rst_n = 0; step(1);
    check("t6_close_dropped", 32'(gif.door_close), 32'd0);
    check("t6_idle", 32'(gif.busy), 32'd0);
    check("t6_cars_init", 32'(gif.car_number), 32'(INIT));
    rst_n = 1; step(1);

    // Both limit switches at once while the door is moving
    do_reset();
    enter_car(6'd51);
    xreq = 1; step(1); xreq = 0;
    mo = 1; mc = 1; step(1); mo = 0; mc = 0;
    check("t7_both_fault", 32'(gif.fault), 32'd1);
    check("t7_open_off", 32'(gif.door_open), 32'd0);
    check("t7_cars_frozen", 32'(gif.car_number), 32'd1);

    // Randomized traffic
    for (int ep = 0; ep < 12; ep++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        ereq  = ($urandom_range(0, 3) != 0);
        epass = ($urandom_range(0, 1) != 0) ? vpw[$urandom_range(0, 9)] : 6'($urandom);
        xreq  = ($urandom_range(0, 2) == 0);
        mo    = ($urandom_range(0, 4) == 0);
        mc    = ($urandom_range(0, 4) == 0);
        if (mo && mc && $urandom_range(0, 15) != 0) mc = 0;
        rst_n = ($urandom_range(0, 199) != 0);
        step(1);
      end
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
